// File: rtl/btle_tx_pkg.sv
// Shared definitions for the BTLE transmit framer: FSM encoding, PHY selection,
// advertising channel indices and the two preamble patterns.
package btle_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PREAMBLE_AA = 2'd1,
        ST_PDU         = 2'd2,
        ST_TAIL        = 2'd3
    } tx_state_e;

    localparam logic PHY_MODE_1M = 1'b0;
    localparam logic PHY_MODE_2M = 1'b1;

    localparam int ADV_CH_37 = 37;
    localparam int ADV_CH_38 = 38;
    localparam int ADV_CH_39 = 39;

    localparam logic [7:0] PREAMBLE_AA0 = 8'hAA;
    localparam logic [7:0] PREAMBLE_AA1 = 8'h55;

endpackage

// File: rtl/btle_pdu_serializer.sv
// PDU octet buffer with one-octet prefetch, LSB-first shift-out and length
// extraction/clipping from header octet 1.
module btle_pdu_serializer
    import btle_tx_pkg::*;
#(
    parameter int PDU_ADDR_WIDTH           = 8,
    parameter int LEN_WIDTH                = 8,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                legacy_len,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic                                wr_en,
    input  logic [PDU_ADDR_WIDTH-1:0]           wr_addr,
    input  logic [7:0]                          wr_data,
    input  logic                                bit_req,
    output logic                                bit_out,
    output logic                                bit_last,
    output logic                                len_clipped
);

    localparam int CW         = PDU_ADDR_WIDTH + 4;
    localparam int BUF_OCTETS = 1 << PDU_ADDR_WIDTH;
    localparam logic [7:0] LEN_MASK = 8'((1 << LEN_WIDTH) - 1);

    logic [7:0]                mem [BUF_OCTETS];
    logic [7:0]                rd_q;
    logic [7:0]                hold;
    logic [7:0]                cur_sr;
    logic [PDU_ADDR_WIDTH-1:0] fetch_addr;
    logic                      pend, hold_v, cur_v, len_known, legacy_q, adv_q;
    logic [2:0]                bit_idx;
    logic [CW-1:0]             bit_cnt, total_bits;
    logic [7:0]                len_mask, len_field;
    logic                      len_over;
    logic [31:0]               n_octets;
    logic                      issue, load_cur;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= mem[fetch_addr];
    end

    always_comb begin
        len_mask = LEN_MASK;
        if (legacy_q) len_mask = adv_q ? 8'h3F : 8'h1F;
        len_field = rd_q & len_mask;
        len_over  = ({24'd0, len_field} + 32'd2) > 32'(BUF_OCTETS);
        n_octets  = len_over ? 32'(BUF_OCTETS) : {24'd0, len_field} + 32'd2;
    end

    // bit_req is a one-cycle pull: bit_out/bit_last describe the bit consumed in that
    // cycle. The hold register refills two cycles after it empties, far inside one octet time.
    assign issue    = !hold_v && !pend;
    assign load_cur = (!cur_v && hold_v) || (bit_req && bit_idx == 3'd7);
    assign bit_out  = cur_sr[0];
    assign bit_last = len_known && (bit_cnt == total_bits - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_addr  <= '0;
            pend        <= 1'b0;
            hold_v      <= 1'b0;
            cur_v       <= 1'b0;
            hold        <= '0;
            cur_sr      <= '0;
            bit_idx     <= '0;
            bit_cnt     <= '0;
            total_bits  <= '0;
            len_known   <= 1'b0;
            legacy_q    <= 1'b0;
            adv_q       <= 1'b0;
            len_clipped <= 1'b0;
        end else if (start) begin
            fetch_addr  <= '0;
            pend        <= 1'b0;
            hold_v      <= 1'b0;
            cur_v       <= 1'b0;
            bit_idx     <= '0;
            bit_cnt     <= '0;
            len_known   <= 1'b0;
            legacy_q    <= legacy_len;
            adv_q       <= (int'(channel_number) == ADV_CH_37) ||
                           (int'(channel_number) == ADV_CH_38) ||
                           (int'(channel_number) == ADV_CH_39);
            len_clipped <= 1'b0;
        end else begin
            len_clipped <= 1'b0;
            pend        <= issue;
            if (issue) fetch_addr <= fetch_addr + 1'b1;
            if (pend) begin
                hold   <= rd_q;
                hold_v <= 1'b1;
                // fetch_addr has already moved past octet 1 when its data lands
                if (!len_known && fetch_addr == PDU_ADDR_WIDTH'(2)) begin
                    len_known   <= 1'b1;
                    total_bits  <= CW'(n_octets << 3);
                    len_clipped <= len_over;
                end
            end else if (load_cur) begin
                hold_v <= 1'b0;
            end
            if (load_cur) begin
                cur_sr <= hold;
                cur_v  <= 1'b1;
            end else if (bit_req) begin
                cur_sr <= cur_sr >> 1;
            end
            if (bit_req) begin
                bit_idx <= bit_idx + 1'b1;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btle_tx_framer.sv
// BTLE transmit framer for LE 1M / LE 2M: emits preamble, access address and PDU
// info bits as one-cycle strobes at the PHY bit rate, then waits for the modulator tail.
module btle_tx_framer
    import btle_tx_pkg::*;
#(
    parameter int CLK_PER_US               = 16,
    parameter int PDU_ADDR_WIDTH           = 8,
    parameter int LEN_WIDTH                = 8,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int TAIL_TIMEOUT             = 512
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                phy_mode,
    input  logic                                legacy_len,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic [31:0]                         access_address,
    input  logic                                pdu_wr_en,
    input  logic [PDU_ADDR_WIDTH-1:0]           pdu_wr_addr,
    input  logic [7:0]                          pdu_wr_data,
    input  logic                                tx_start,
    input  logic                                tx_abort,
    input  logic                                tail_done,
    output logic                                info_bit,
    output logic                                info_bit_valid,
    output logic                                info_bit_valid_last,
    output logic                                pdu_bit,
    output logic                                busy,
    output logic                                done,
    output logic                                aborted,
    output logic                                len_clipped,
    output logic                                tail_timeout
);

    localparam int DW = $clog2(CLK_PER_US + 1);
    localparam int TW = $clog2(TAIL_TIMEOUT + 1);
    localparam logic [DW-1:0] RELOAD_1M = DW'(CLK_PER_US - 1);
    localparam logic [DW-1:0] RELOAD_2M = DW'(CLK_PER_US / 2 - 1);

    tx_state_e     state, state_nxt;
    logic          mode_2m;
    logic [47:0]   hdr_sr;
    logic [5:0]    hdr_left;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] tail_cnt;
    logic [7:0]    preamble;
    logic          start_ok, tick, tail_expired;
    logic          hdr_tick, pdu_tick, end_normal, end_timeout, end_abort;
    logic          ser_bit, ser_last;

    assign preamble     = access_address[0] ? PREAMBLE_AA1 : PREAMBLE_AA0;
    assign start_ok     = (state == ST_IDLE) && tx_start && !tx_abort;
    assign tick         = (div_cnt == '0);
    assign tail_expired = (tail_cnt == TW'(TAIL_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:        if (start_ok) state_nxt = ST_PREAMBLE_AA;
            ST_PREAMBLE_AA: if (tx_abort) state_nxt = ST_IDLE;
                            else if (tick && hdr_left == 6'd1) state_nxt = ST_PDU;
            ST_PDU:         if (tx_abort) state_nxt = ST_IDLE;
                            else if (tick && ser_last) state_nxt = ST_TAIL;
            ST_TAIL:        if (tx_abort || tail_done || tail_expired) state_nxt = ST_IDLE;
            default:        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        hdr_tick    = (state == ST_PREAMBLE_AA) && tick && !tx_abort;
        pdu_tick    = (state == ST_PDU) && tick && !tx_abort;
        end_normal  = (state == ST_TAIL) && !tx_abort && (tail_done || tail_expired);
        end_timeout = (state == ST_TAIL) && !tx_abort && !tail_done && tail_expired;
        end_abort   = (state != ST_IDLE) && tx_abort;
    end

    // Strobes are registered, so an accepted start shows its first strobe two cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_2m             <= 1'b0;
            hdr_sr              <= '0;
            hdr_left            <= '0;
            div_cnt             <= '0;
            tail_cnt            <= '0;
            info_bit            <= 1'b0;
            info_bit_valid      <= 1'b0;
            info_bit_valid_last <= 1'b0;
            pdu_bit             <= 1'b0;
            done                <= 1'b0;
            aborted             <= 1'b0;
            tail_timeout        <= 1'b0;
        end else begin
            info_bit_valid      <= 1'b0;
            info_bit_valid_last <= 1'b0;
            pdu_bit             <= 1'b0;
            done                <= end_normal;
            aborted             <= end_abort;
            tail_timeout        <= end_timeout;
            if (start_ok) begin
                mode_2m  <= (phy_mode == PHY_MODE_2M);
                div_cnt  <= '0;
                hdr_sr   <= (phy_mode == PHY_MODE_2M) ? {access_address, preamble, preamble}
                                                      : {8'h00, access_address, preamble};
                hdr_left <= (phy_mode == PHY_MODE_2M) ? 6'd48 : 6'd40;
            end else if (state == ST_PREAMBLE_AA || state == ST_PDU) begin
                div_cnt <= tick ? (mode_2m ? RELOAD_2M : RELOAD_1M) : div_cnt - 1'b1;
            end
            if (hdr_tick) begin
                info_bit       <= hdr_sr[0];
                info_bit_valid <= 1'b1;
                hdr_sr         <= hdr_sr >> 1;
                hdr_left       <= hdr_left - 1'b1;
            end
            if (pdu_tick) begin
                info_bit            <= ser_bit;
                info_bit_valid      <= 1'b1;
                info_bit_valid_last <= ser_last;
                pdu_bit             <= 1'b1;
            end
            if (state != ST_TAIL)  tail_cnt <= '0;
            else if (!tail_expired) tail_cnt <= tail_cnt + 1'b1;
        end
    end

    btle_pdu_serializer #(
        .PDU_ADDR_WIDTH          (PDU_ADDR_WIDTH),
        .LEN_WIDTH               (LEN_WIDTH),
        .CHANNEL_NUMBER_BIT_WIDTH(CHANNEL_NUMBER_BIT_WIDTH)
    ) u_serializer (
        .clk           (clk),
        .rst           (rst),
        .start         (start_ok),
        .legacy_len    (legacy_len),
        .channel_number(channel_number),
        .wr_en         (pdu_wr_en),
        .wr_addr       (pdu_wr_addr),
        .wr_data       (pdu_wr_data),
        .bit_req       (pdu_tick),
        .bit_out       (ser_bit),
        .bit_last      (ser_last),
        .len_clipped   (len_clipped)
    );

endmodule

// File: tb/tb_btle_tx_framer.sv
// Randomized bench for btle_tx_framer: a bit-level packet model fills an expected
// queue of {cycle, bit, pdu_bit, last} per strobe; control pulses are checked by cycle.
module tb_btle_tx_framer;

    localparam int CLK_PER_US   = 16;
    localparam int TAIL_TIMEOUT = 512;
    localparam int BUF_OCTETS   = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phy_mode = 1'b0, legacy_len = 1'b0;
    logic [5:0]  channel_number = '0;
    logic [31:0] access_address = '0;
    logic        pdu_wr_en = 1'b0;
    logic [7:0]  pdu_wr_addr = '0, pdu_wr_data = '0;
    logic        tx_start = 1'b0, tx_abort = 1'b0, tail_done = 1'b0;
    logic        info_bit, info_bit_valid, info_bit_valid_last, pdu_bit;
    logic        busy, done, aborted, len_clipped, tail_timeout;

    int          checks = 0, failures = 0, cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;
    logic [7:0]  buf_model [BUF_OCTETS];
    int          done_cnt = 0, abort_cnt = 0, clip_cnt = 0, tmo_cnt = 0;
    int          done_cyc = 0, abort_cyc = 0, tmo_cyc = 0, last_cyc = 0;
    bit          seen_last = 0;

    btle_tx_framer #(
        .CLK_PER_US(CLK_PER_US), .PDU_ADDR_WIDTH(8), .LEN_WIDTH(8),
        .CHANNEL_NUMBER_BIT_WIDTH(6), .TAIL_TIMEOUT(TAIL_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .phy_mode(phy_mode), .legacy_len(legacy_len),
        .channel_number(channel_number), .access_address(access_address),
        .pdu_wr_en(pdu_wr_en), .pdu_wr_addr(pdu_wr_addr), .pdu_wr_data(pdu_wr_data),
        .tx_start(tx_start), .tx_abort(tx_abort), .tail_done(tail_done),
        .info_bit(info_bit), .info_bit_valid(info_bit_valid),
        .info_bit_valid_last(info_bit_valid_last), .pdu_bit(pdu_bit), .busy(busy),
        .done(done), .aborted(aborted), .len_clipped(len_clipped), .tail_timeout(tail_timeout)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard / pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (info_bit_valid) begin
                check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("strobe", {29'(cyc), info_bit, pdu_bit, info_bit_valid_last}, mon_e);
                end
                if (info_bit_valid_last) begin
                    seen_last = 1;
                    last_cyc  = cyc;
                end
            end
            if (done)         begin done_cnt++;  done_cyc  = cyc; end
            if (aborted)      begin abort_cnt++; abort_cyc = cyc; end
            if (tail_timeout) begin tmo_cnt++;   tmo_cyc   = cyc; end
            if (len_clipped)  clip_cnt++;
        end
    end

    // reference packet model: list of on-air bits, then one strobe every bit period
    function automatic void build_expected(input int st, input bit m2, input logic [31:0] aa,
                                           input bit legacy, input int ch, output bit clip);
        bit       bq[$];
        bit       pq[$];
        logic [7:0] pre;
        int       len, n_oct, p, total;
        pre = aa[0] ? 8'h55 : 8'hAA;
        p   = m2 ? CLK_PER_US / 2 : CLK_PER_US;
        for (int r = 0; r < (m2 ? 2 : 1); r++)
            for (int i = 0; i < 8; i++) begin bq.push_back(pre[i]); pq.push_back(1'b0); end
        for (int i = 0; i < 32; i++) begin bq.push_back(aa[i]); pq.push_back(1'b0); end
        len = int'(buf_model[1]);
        if (legacy) len = (ch >= 37 && ch <= 39) ? len % 64 : len % 32;
        n_oct = len + 2;
        clip  = (n_oct > BUF_OCTETS);
        if (clip) n_oct = BUF_OCTETS;
        for (int o = 0; o < n_oct; o++)
            for (int i = 0; i < 8; i++) begin bq.push_back(buf_model[o][i]); pq.push_back(1'b1); end
        total = bq.size();
        for (int k = 0; k < total; k++)
            exp_q.push_back({29'(st + 2 + k * p), bq[k], pq[k], (k == total - 1)});
    endfunction

    // driver tasks (entered and left at #1 after a rising edge)
    task automatic write_octet(input int a, input logic [7:0] d);
        pdu_wr_en = 1'b1; pdu_wr_addr = a[7:0]; pdu_wr_data = d;
        buf_model[a] = d;
        @(posedge clk); #1;
        pdu_wr_en = 1'b0;
    endtask

    task automatic run_packet(input bit m2, input logic [31:0] aa, input bit legacy, input int ch,
                              input int tail_delay, input int hold_cycles);
        int st, last_c, guard, exp_done, done0, clip0, tmo0, ab0;
        bit clip_exp;
        done0 = done_cnt; clip0 = clip_cnt; tmo0 = tmo_cnt; ab0 = abort_cnt; seen_last = 0;
        check("idle_before_start", busy, 0);
        phy_mode = m2; access_address = aa; legacy_len = legacy; channel_number = 6'(ch);
        tx_start = 1'b1;
        st = cyc;
        build_expected(st, m2, aa, legacy, ch, clip_exp);
        @(posedge clk); #1;
        check("busy_rise", busy, 1);
        repeat (hold_cycles - 1) begin @(posedge clk); #1; end
        tx_start = 1'b0; phy_mode = ~m2; access_address = ~aa;
        guard = 0;
        while (!seen_last && guard < 40000) begin @(posedge clk); #1; guard++; end
        check("last_seen", 32'(seen_last), 1);
        last_c = last_cyc;
        if (tail_delay >= 0) begin
            while (cyc < last_c + tail_delay) begin @(posedge clk); #1; end
            tail_done = 1'b1;
            @(posedge clk); #1;
            tail_done = 1'b0;
            exp_done = last_c + tail_delay + 1;
        end else begin
            exp_done = last_c + TAIL_TIMEOUT;
        end
        guard = 0;
        while (done_cnt == done0 && guard < 2000) begin @(posedge clk); #1; guard++; end
        check("done_count", done_cnt - done0, 1);
        check("done_cycle", done_cyc, exp_done);
        check("tail_timeout_count", tmo_cnt - tmo0, (tail_delay < 0) ? 1 : 0);
        if (tail_delay < 0) check("tail_timeout_cycle", tmo_cyc, exp_done);
        check("len_clipped_count", clip_cnt - clip0, 32'(clip_exp));
        check("no_abort", abort_cnt - ab0, 0);
        check("exp_drained", exp_q.size(), 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  st, ab0, done0;
        bit  clip_unused;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {info_bit, info_bit_valid, info_bit_valid_last, pdu_bit, busy,
                                done, aborted, len_clipped, tail_timeout}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic 1M advertising packet, tail_done five cycles after the last bit
        write_octet(0, 8'h40); write_octet(1, 8'h02); write_octet(2, 8'h11); write_octet(3, 8'h22);
        run_packet(1'b0, 32'h8E89BED6, 1'b1, 37, 5, 1);
        // same packet in 2M, tail never answered
        run_packet(1'b1, 32'h8E89BED6, 1'b1, 37, -1, 1);
        // 2M with access_address[0]=1 selects the 0x55 preamble
        run_packet(1'b1, 32'h00000001, 1'b1, 38, 3, 1);
        // tx_start held for 100 cycles must not restart the packet
        run_packet(1'b0, 32'h12345678, 1'b1, 39, 2, 100);

        // abort right after strobe 20 is visible
        ab0 = abort_cnt; done0 = done_cnt; seen_last = 0;
        phy_mode = 1'b0; access_address = 32'h8E89BED6; legacy_len = 1'b1; channel_number = 6'd37;
        tx_start = 1'b1; st = cyc;
        build_expected(st, 1'b0, 32'h8E89BED6, 1'b1, 37, clip_unused);
        while (exp_q.size() > 20) void'(exp_q.pop_back());
        @(posedge clk); #1;
        tx_start = 1'b0;
        while (cyc < st + 2 + 19 * CLK_PER_US) begin @(posedge clk); #1; end
        check("abort_busy_before", busy, 1);
        tx_abort = 1'b1;
        @(posedge clk); #1;
        tx_abort = 1'b0;
        check("abort_busy_after", busy, 0);
        repeat (3 * CLK_PER_US) begin @(posedge clk); #1; end
        check("abort_pulse_count", abort_cnt - ab0, 1);
        check("abort_pulse_cycle", abort_cyc, st + 2 + 19 * CLK_PER_US + 1);
        check("abort_no_done", done_cnt - done0, 0);
        check("abort_no_last", 32'(seen_last), 0);
        check("abort_drained", exp_q.size(), 0);

        // start together with abort in IDLE starts nothing
        ab0 = abort_cnt;
        tx_start = 1'b1; tx_abort = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0; tx_abort = 1'b0;
        check("start_abort_busy", busy, 0);
        repeat (10) begin @(posedge clk); #1; end
        check("start_abort_busy_later", busy, 0);
        check("start_abort_no_pulse", abort_cnt - ab0, 0);

        // asynchronous reset in the middle of the PDU, then a clean packet
        phy_mode = 1'b0; access_address = 32'h8E89BED6; legacy_len = 1'b1; channel_number = 6'd37;
        tx_start = 1'b1; st = cyc;
        build_expected(st, 1'b0, 32'h8E89BED6, 1'b1, 37, clip_unused);
        @(posedge clk); #1;
        tx_start = 1'b0;
        while (cyc < st + 2 + 44 * CLK_PER_US) begin @(posedge clk); #1; end
        check("busy_before_reset", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {info_bit, info_bit_valid, info_bit_valid_last, pdu_bit, busy,
                                      done, aborted, len_clipped, tail_timeout}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        write_octet(0, 8'h41); write_octet(1, 8'h03);
        for (int a = 2; a < 5; a++) write_octet(a, 8'($urandom));
        run_packet(1'b0, $urandom, 1'b1, 12, 4, 1);

        // legacy length on a data channel: 0xFF masks to 31
        for (int a = 0; a < 34; a++) write_octet(a, 8'($urandom));
        write_octet(1, 8'hFF);
        run_packet(1'b0, $urandom, 1'b1, 5, 2, 1);

        // full-width length clipped to the buffer size
        for (int a = 0; a < BUF_OCTETS; a++) write_octet(a, 8'($urandom));
        write_octet(1, 8'hFF);
        run_packet(1'b1, $urandom, 1'b0, 5, 6, 1);

        // randomized legacy packets
        for (int n = 0; n < 3; n++) begin
            for (int a = 0; a < 66; a++) write_octet(a, 8'($urandom));
            run_packet(1'($urandom_range(0, 1)), $urandom, 1'b1, int'($urandom_range(0, 39)),
                       int'($urandom_range(1, 20)), int'($urandom_range(1, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btle_tx_framer.md
Name: btle_tx_framer

Overview:
Parametrised successor to the fixed 1M BTLE transmit front end. It builds the on-air info-bit stream (auto preamble, access address, PDU header and payload from a PDU octet buffer) for the LE 1M or LE 2M PHY, selected per packet. It emits one-cycle bit strobes at the PHY bit rate into the existing crc24 -> scramble -> gfsk_modulation chain, and provides start/abort/busy/done control plus a post-packet tail wait.

Parameters:
CLK_PER_US, 16, clocks per microsecond; even, >=4; bit period P = CLK_PER_US (1M) or CLK_PER_US/2 (2M)
PDU_ADDR_WIDTH, 8, PDU buffer depth 2^PDU_ADDR_WIDTH octets
LEN_WIDTH, 8, payload length field width (<=8)
CHANNEL_NUMBER_BIT_WIDTH, 6, channel index width
TAIL_TIMEOUT, 512, max clocks to wait for tail_done after last bit

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
phy_mode  in  1  0=LE 1M, 1=LE 2M; sampled on accepted tx_start
legacy_len  in  1  1: mask length to 6 bits (adv ch 37-39) or 5 bits (data ch); 0: full LEN_WIDTH
channel_number  in  CHANNEL_NUMBER_BIT_WIDTH  selects adv vs data masking
access_address  in  32  sampled on accepted tx_start
pdu_wr_en  in  1  PDU buffer write strobe
pdu_wr_addr  in  PDU_ADDR_WIDTH  write address
pdu_wr_data  in  8  write octet
tx_start  in  1  start request (level or pulse)
tx_abort  in  1  abort request
tail_done  in  1  downstream last-sample indication (modulator valid_last)
info_bit  out  1  current bit, LSB-first per octet
info_bit_valid  out  1  one-cycle strobe per bit
info_bit_valid_last  out  1  with the last PDU bit's strobe
pdu_bit  out  1  high with strobes belonging to the PDU (CRC-covered) section
busy  out  1  packet in progress (not IDLE)
done  out  1  one-cycle pulse on normal return to IDLE
aborted  out  1  one-cycle pulse on abort
len_clipped  out  1  one-cycle pulse when length exceeds buffer
tail_timeout  out  1  one-cycle pulse, coincident with done, when timeout ended the tail

Behaviour:
- Reset: all outputs 0, state IDLE, bit counters 0. Buffer contents undefined after reset.
- States: IDLE -> PREAMBLE_AA -> PDU -> TAIL -> IDLE.
- IDLE:
  - tx_start (without tx_abort) latches phy_mode and access_address and enters PREAMBLE_AA.
  - tx_start while busy is ignored.
- Bit strobe timing:
  - Accepted tx_start at cycle 0; strobes at cycles 2 + k*P, k = 0,1,2...
  - Strobes are contiguous across section boundaries with no gaps.
  - info_bit is held stable between strobes.
- Preamble:
  - Preamble byte = 0xAA if access_address[0]==0, else 0x55.
  - 1M sends the byte once (8 bits); 2M sends it twice (16 bits), LSB first.
  - Then 32 access-address bits, LSB first.
  - pdu_bit is 0 throughout.
- PDU:
  - Octets are read from buffer addresses 0 .. L+1, LSB first; pdu_bit is 1.
  - L = octet[1] masked as follows:
    - legacy_len=1 and channel 37/38/39: [5:0]
    - legacy_len=1, other channels: [4:0]
    - legacy_len=0: [LEN_WIDTH-1:0]
  - If L+2 > 2^PDU_ADDR_WIDTH, L is clipped to 2^PDU_ADDR_WIDTH-2 and len_clipped pulses once.
  - The length is resolved before the first header bit strobe. The buffer has 1-cycle read latency; it is prefetched so it never stalls strobes.
  - info_bit_valid_last accompanies strobe number (L+2)*8 of the PDU; the state then goes to TAIL.
- Buffer writes:
  - Accepted every cycle.
  - A write to an address not yet fetched in the current packet affects output; this is legal, not guarded.
- TAIL:
  - tail_done -> IDLE next cycle with a done pulse.
  - Otherwise, after TAIL_TIMEOUT cycles -> IDLE with done and tail_timeout pulses.
  - tail_done is ignored outside TAIL.
- Abort:
  - tx_abort in any non-IDLE state: no further strobes from the next cycle, and valid_last is never issued.
  - State goes to IDLE, with aborted pulse and busy low one cycle after tx_abort; done is not pulsed.
  - tx_abort together with tx_start in IDLE: nothing starts, no pulse.
- busy is high from cycle 1 after the accepted start until the cycle IDLE is re-entered.
- Width rules:
  - Bit counter wide enough for 16 + 32 + 8*2^PDU_ADDR_WIDTH.
  - Clock divider wide enough for CLK_PER_US.

Decomposition:
- Package btle_tx_pkg: state encoding, PHY_MODE_1M/PHY_MODE_2M, ADV_CH_37/38/39, PREAMBLE_AA0 = 0xAA, PREAMBLE_AA1 = 0x55.
- Sub-module btle_pdu_serializer:
  - contents: the buffer (existing dpram), octet prefetch, shift register, length extraction/clipping
  - interface: bit request in, bit/last out
- Top: FSM, divider, preamble/AA shift, tail timer.

Test Plan:
1. 1M, AA=0x8E89BED6, ch37, legacy_len=1, buffer {0x40,0x02,0x11,0x22} -> 72 strobes every 16 clk, first at cycle 2; bits 1-8 = 0,1,0,1,0,1,0,1; pdu_bit on strobes 41-72; valid_last on strobe 72.
2. Same packet, 2M, CLK_PER_US=16 -> 16 preamble bits, 80 strobes every 8 clk, valid_last on strobe 80; AA=0x00000001 gives preamble 0x55.
3. Octet1=0xFF: ch5, legacy_len=1 -> L=31, 264 PDU bits. legacy_len=0, PDU_ADDR_WIDTH=8 -> L clipped to 254, len_clipped pulse, 2048 PDU bits.
4. tx_abort at strobe 20 -> no strobe 21, aborted pulse, busy low next cycle, no done. tx_start held during a packet -> no restart; tx_start+tx_abort in IDLE -> stays IDLE.
5. TAIL with tail_done 5 cycles after valid_last -> done on the following cycle. tail_done never -> done and tail_timeout after 512 cycles.
6. rst asserted mid-PDU -> all outputs 0 asynchronously; new tx_start after release gives a normal packet from address 0.
